// File: rtl/obstacle_collision_monitor_if.sv
// Sprite-update to collision-monitor link: frame tick, sprite positions, passed flag,
// and the monitor's status/score outputs back to display and game control.
interface obstacle_collision_monitor_if;
   logic        update;
   logic [7:0]  playerX;
   logic [8:0]  playerY;
   logic [7:0]  obstacleX;
   logic [8:0]  obstacleY;
   logic [3:0]  obstacleId;
   logic        passed;
   logic        busy;
   logic        collision;
   logic        gameOver;
   logic [15:0] score;

   modport master (
      output update, playerX, playerY, obstacleX, obstacleY, obstacleId, passed,
      input  busy, collision, gameOver, score
   );

   modport slave (
      input  update, playerX, playerY, obstacleX, obstacleY, obstacleId, passed,
      output busy, collision, gameOver, score
   );
endinterface

// File: rtl/obstacle_collision_monitor.sv
// Per-frame player/obstacle bounding-box collision check with hit debounce,
// BCD passed-obstacle score and latched game over.
module obstacle_collision_monitor #(
   parameter logic [7:0] PLAYER_W   = 8'd24,
   parameter logic [8:0] PLAYER_H   = 9'd32,
   parameter logic [7:0] LOW_W      = 8'd20,
   parameter logic [7:0] HIGH_W     = 8'd20,
   parameter logic [8:0] OBST_H     = 9'd24,
   parameter logic [1:0] HIT_FRAMES = 2'd2
) (
   input logic                           clock,
   input logic                           reset,
   obstacle_collision_monitor_if.slave   bus
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP_X, S_CMP_Y, S_SCORE, S_OVER} state_t;

   state_t      r_state;
   logic [7:0]  r_px, r_ox, r_ow;
   logic [8:0]  r_py, r_oy;
   logic        r_valid, r_passed, r_passed_prev, r_x_ov;
   logic [1:0]  r_hit_count;
   logic        r_busy, r_collision, r_game_over;
   logic [15:0] r_score;

   logic [8:0]  w_ox_end, w_px_end;
   logic [9:0]  w_oy_end, w_py_end;
   logic        w_x_ov, w_y_ov;
   logic [15:0] w_score_inc;
   logic [4:0]  w_carry;

   // Extended-width sums so boxes near the screen edge never wrap around.
   assign w_ox_end = {1'b0, r_ox} + {1'b0, r_ow};
   assign w_px_end = {1'b0, r_px} + {1'b0, PLAYER_W};
   assign w_oy_end = {1'b0, r_oy} + {1'b0, OBST_H};
   assign w_py_end = {1'b0, r_py} + {1'b0, PLAYER_H};
   assign w_x_ov   = ({1'b0, r_px} < w_ox_end) && ({1'b0, r_ox} < w_px_end);
   assign w_y_ov   = ({1'b0, r_py} < w_oy_end) && ({1'b0, r_oy} < w_py_end);

   assign w_carry[0] = 1'b1;
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
         wire [3:0] w_digit = r_score[gi*4 +: 4];
         assign w_score_inc[gi*4 +: 4] = !w_carry[gi] ? w_digit :
                                         (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
         assign w_carry[gi+1] = w_carry[gi] && (w_digit == 4'd9);
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_px          <= '0;
         r_py          <= '0;
         r_ox          <= '0;
         r_oy          <= '0;
         r_ow          <= '0;
         r_valid       <= 1'b0;
         r_passed      <= 1'b0;
         r_passed_prev <= 1'b0;
         r_x_ov        <= 1'b0;
         r_hit_count   <= '0;
         r_busy        <= 1'b0;
         r_collision   <= 1'b0;
         r_game_over   <= 1'b0;
         r_score       <= 16'h0000;
      end else begin
         r_collision <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.update) begin
                  r_state <= S_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               r_px     <= bus.playerX;
               r_py     <= bus.playerY;
               r_ox     <= bus.obstacleX;
               r_oy     <= bus.obstacleY;
               r_passed <= bus.passed;
               case (bus.obstacleId)
                  4'd6, 4'd7: begin r_ow <= LOW_W;  r_valid <= 1'b1; end
                  4'd8:       begin r_ow <= HIGH_W; r_valid <= 1'b1; end
                  default:    begin r_ow <= 8'd0;   r_valid <= 1'b0; end
               endcase
               r_state <= S_CMP_X;
            end
            S_CMP_X: begin
               r_x_ov  <= w_x_ov;
               r_state <= S_CMP_Y;
            end
            S_CMP_Y: begin
               if (r_valid && r_x_ov && w_y_ov)
                  r_hit_count <= (r_hit_count == 2'd3) ? 2'd3 : r_hit_count + 2'd1;
               else
                  r_hit_count <= 2'd0;
               r_state <= S_SCORE;
            end
            S_SCORE: begin
               r_busy <= 1'b0;
               // A declared collision takes priority over a pass in the same frame.
               if (r_hit_count >= HIT_FRAMES) begin
                  r_collision <= 1'b1;
                  r_game_over <= 1'b1;
                  r_state     <= S_OVER;
               end else begin
                  if (r_passed && !r_passed_prev && !w_carry[4])
                     r_score <= w_score_inc;
                  r_passed_prev <= r_passed;
                  r_state       <= S_IDLE;
               end
            end
            S_OVER: r_state <= S_OVER;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.collision = r_collision;
   assign bus.gameOver  = r_game_over;
   assign bus.score     = r_score;
endmodule

// File: tb/tb_obstacle_collision_monitor.sv
// Directed bench for obstacle_collision_monitor: scoring, BCD carry/saturation,
// overlap edges, debounce, game over, async reset abort and dropped updates.
module tb_obstacle_collision_monitor;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   obstacle_collision_monitor_if bus_if();

   obstacle_collision_monitor dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One frame: pulse update, then sample busy/collision after edges N..N+5.
   task automatic run_frame(input logic [7:0] px, input logic [8:0] py, input logic [7:0] ox,
                            input logic [8:0] oy, input logic [3:0] id, input logic pas,
                            output logic [5:0] bmask, output logic [5:0] cmask);
      @(negedge clock);
      bus_if.playerX    = px;
      bus_if.playerY    = py;
      bus_if.obstacleX  = ox;
      bus_if.obstacleY  = oy;
      bus_if.obstacleId = id;
      bus_if.passed     = pas;
      bus_if.update     = 1'b1;
      @(negedge clock);
      bus_if.update = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bmask[k] = bus_if.busy;
         cmask[k] = bus_if.collision;
         if (k < 5) @(negedge clock);
      end
      $display("frame p=(%0d,%0d) o=(%0d,%0d) id=%0d passed=%0b busy=%b col=%b score=%h over=%0b",
               px, py, ox, oy, id, pas, bmask, cmask, bus_if.score, bus_if.gameOver);
   endtask

   logic [5:0] bm, cm;
   logic [7:0] bm8;

   initial begin
      bus_if.update = 1'b0;
      bus_if.playerX = '0;  bus_if.playerY = '0;
      bus_if.obstacleX = '0; bus_if.obstacleY = '0;
      bus_if.obstacleId = '0; bus_if.passed = 1'b0;
      repeat (3) @(negedge clock);
      check_value("rst_busy", {31'd0, bus_if.busy}, 0);
      check_value("rst_col", {31'd0, bus_if.collision}, 0);
      check_value("rst_over", {31'd0, bus_if.gameOver}, 0);
      check_value("rst_score", {16'd0, bus_if.score}, 32'h0000);
      reset = 1'b0;

      // 1: no overlap, busy exactly 4 clocks
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
      check_value("t1_busy", {26'd0, bm}, 32'b001111);
      check_value("t1_col", {26'd0, cm}, 0);
      check_value("t1_score", {16'd0, bus_if.score}, 32'h0000);

      // 2: passed held over 3 updates counts once
      for (int i = 0; i < 3; i++) run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      check_value("t2_held", {16'd0, bus_if.score}, 32'h0001);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      check_value("t2_second", {16'd0, bus_if.score}, 32'h0002);

      // 3: carries into hundreds, then saturation at 9999
      for (int i = 0; i < 97; i++) begin
         run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
         run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      end
      check_value("t3_0099", {16'd0, bus_if.score}, 32'h0099);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      check_value("t3_0100", {16'd0, bus_if.score}, 32'h0100);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
      @(negedge clock);
      force dut.r_score = 16'h9998;
      @(negedge clock);
      release dut.r_score;
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      check_value("t3_9999", {16'd0, bus_if.score}, 32'h9999);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      check_value("t3_sat", {16'd0, bus_if.score}, 32'h9999);

      // 6: reset during CMP_X with hitCount=1
      run_frame(8'd63, 9'd100, 8'd63, 9'd110, 4'd7, 1'b0, bm, cm);
      check_value("t6_first_hit", {26'd0, cm}, 0);
      @(negedge clock);
      bus_if.update = 1'b1;
      @(negedge clock);
      bus_if.update = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_value("t6_rst_busy", {31'd0, bus_if.busy}, 0);
      check_value("t6_rst_col", {31'd0, bus_if.collision}, 0);
      check_value("t6_rst_over", {31'd0, bus_if.gameOver}, 0);
      check_value("t6_rst_score", {16'd0, bus_if.score}, 32'h0000);
      @(negedge clock);
      reset = 1'b0;
      run_frame(8'd63, 9'd100, 8'd63, 9'd110, 4'd7, 1'b0, bm, cm);
      check_value("t6_hitcnt_cleared", {26'd0, cm}, 0);
      check_value("t6_busy", {26'd0, bm}, 32'b001111);

      // 6: update while busy is dropped
      @(negedge clock);
      bus_if.playerX = 8'd63;  bus_if.playerY = 9'd100;
      bus_if.obstacleX = 8'd63; bus_if.obstacleY = 9'd419;
      bus_if.obstacleId = 4'd6; bus_if.passed = 1'b1;
      bus_if.update = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         bus_if.update = (k == 0);
         bm8[k] = bus_if.busy;
      end
      $display("drop test busy=%b score=%h", bm8, bus_if.score);
      check_value("t6_drop_busy", {24'd0, bm8}, 32'b00001111);
      check_value("t6_drop_score", {16'd0, bus_if.score}, 32'h0001);

      // 5/4: touching edge, invalid id, debounce, collision
      run_frame(8'd82, 9'd100, 8'd63, 9'd110, 4'd6, 1'b0, bm, cm);
      check_value("t5_a_col", {26'd0, cm}, 0);
      run_frame(8'd83, 9'd100, 8'd63, 9'd110, 4'd6, 1'b0, bm, cm);
      check_value("t5_touch_col", {26'd0, cm}, 0);
      run_frame(8'd63, 9'd100, 8'd63, 9'd110, 4'd0, 1'b0, bm, cm);
      check_value("t5_id0_col", {26'd0, cm}, 0);
      run_frame(8'd82, 9'd100, 8'd63, 9'd110, 4'd6, 1'b0, bm, cm);
      check_value("t5_d_col", {26'd0, cm}, 0);
      check_value("t5_d_over", {31'd0, bus_if.gameOver}, 0);
      run_frame(8'd63, 9'd100, 8'd63, 9'd110, 4'd7, 1'b1, bm, cm);
      check_value("t4_col_pulse", {26'd0, cm}, 32'b010000);
      check_value("t4_over", {31'd0, bus_if.gameOver}, 1);
      check_value("t4_score_frozen", {16'd0, bus_if.score}, 32'h0001);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b0, bm, cm);
      run_frame(8'd63, 9'd100, 8'd63, 9'd419, 4'd6, 1'b1, bm, cm);
      check_value("t4_over_busy", {26'd0, bm}, 0);
      check_value("t4_over_col", {26'd0, cm}, 0);
      check_value("t4_over_score", {16'd0, bus_if.score}, 32'h0001);
      check_value("t4_over_latched", {31'd0, bus_if.gameOver}, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
